// File: rtl/radio_seq_pkg.sv
// -----------------------------------------------------------------------------
// radio_seq_pkg
// Shared types and helpers for the per-lane radio power sequencer.
//   radio_seq_state_e : per-lane sequencing state
//   cnt_w()           : width of the warm-up / cool-down down-counter
// -----------------------------------------------------------------------------
package radio_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WARM,
        ST_TX,
        ST_RX,
        ST_SWAP,
        ST_COOL
    } radio_seq_state_e;

    // Wide enough to hold the larger of the two load values (len-1), with
    // headroom so a length of exactly 2^n still fits.
    function automatic int cnt_w(input int warm_cyc, input int cool_cyc);
        int longest;
        longest = (warm_cyc > cool_cyc) ? warm_cyc : cool_cyc;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/radio_seq_lane.sv
// -----------------------------------------------------------------------------
// radio_seq_lane
// One lane of the radio power sequencer: LDO up, warm-up wait, TX/RX path,
// break-before-make on mode change, cool-down before LDO off.
// Ports:
//   ck, arst_n       : clock, async active-low reset
//   i_en             : lane enable (synchronized)
//   i_rx             : lane mode, 1 = RX, 0 = TX (synchronized)
//   i_err_clr        : clears o_seq_err
//   o_ldo_en         : LDO enable
//   o_tx_path_en     : TX path enable
//   o_rx_path_en     : RX path enable
//   o_lane_ready     : lane is in TX or RX
//   o_ready_pulse    : one cycle on entry to TX/RX from warm-up
//   o_seq_err        : sticky "RX requested without enable" flag
// -----------------------------------------------------------------------------
module radio_seq_lane
    import radio_seq_pkg::*;
#(
    parameter int WARM_CYC = 16,
    parameter int COOL_CYC = 8
) (
    input  logic ck,
    input  logic arst_n,
    input  logic i_en,
    input  logic i_rx,
    input  logic i_err_clr,
    output logic o_ldo_en,
    output logic o_tx_path_en,
    output logic o_rx_path_en,
    output logic o_lane_ready,
    output logic o_ready_pulse,
    output logic o_seq_err
);

    localparam int CNT_W = cnt_w(WARM_CYC, COOL_CYC);
    localparam logic [CNT_W-1:0] WARM_LD = CNT_W'(WARM_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOL_CYC - 1);

    radio_seq_state_e r_state;
    radio_seq_state_e w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ready_pulse;
    logic             w_ready_pulse_nxt;
    logic             r_seq_err;
    logic             w_seq_err_set;

    // NOTE: every signal gets a default at the top of always_comb so no
    // branch can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_ready_pulse_nxt = 1'b0;

        unique case (r_state)
            ST_OFF: begin
                if (i_en) begin
                    w_state_nxt = ST_WARM;
                    w_cnt_nxt   = WARM_LD;
                end
            end
            ST_WARM: begin
                // Losing enable during warm-up still has to cool the LDO down.
                if (!i_en) begin
                    w_state_nxt = ST_COOL;
                    w_cnt_nxt   = COOL_LD;
                end else if (r_cnt == '0) begin
                    w_state_nxt       = i_rx ? ST_RX : ST_TX;
                    w_ready_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_TX: begin
                if (!i_en) begin
                    w_state_nxt = ST_COOL;
                    w_cnt_nxt   = COOL_LD;
                end else if (i_rx) begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_RX: begin
                if (!i_en) begin
                    w_state_nxt = ST_COOL;
                    w_cnt_nxt   = COOL_LD;
                end else if (!i_rx) begin
                    w_state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                // Single dead cycle with both paths off; the mode sampled here
                // picks the new path, so a bounce back is also handled.
                if (!i_en) begin
                    w_state_nxt = ST_COOL;
                    w_cnt_nxt   = COOL_LD;
                end else begin
                    w_state_nxt = i_rx ? ST_RX : ST_TX;
                end
            end
            ST_COOL: begin
                // Enable is deliberately ignored until OFF is reached.
                if (r_cnt == '0) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_seq_err_set = (r_state == ST_OFF) && !i_en && i_rx;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge ck or negedge arst_n) begin
        if (!arst_n) begin
            r_state       <= ST_OFF;
            r_cnt         <= '0;
            r_ready_pulse <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ready_pulse <= w_ready_pulse_nxt;
            // Set dominates a concurrent clear.
            r_seq_err     <= w_seq_err_set | (r_seq_err & ~i_err_clr);
        end
    end

    // Moore decode straight from the state register: no input reaches an
    // output without passing a flop, and reset drops everything at once.
    assign o_ldo_en      = (r_state != ST_OFF);
    assign o_tx_path_en  = (r_state == ST_TX);
    assign o_rx_path_en  = (r_state == ST_RX);
    assign o_lane_ready  = (r_state == ST_TX) || (r_state == ST_RX);
    assign o_ready_pulse = r_ready_pulse;
    assign o_seq_err     = r_seq_err;

endmodule

// File: rtl/radio_seq.sv
// -----------------------------------------------------------------------------
// radio_seq
// Per-lane radio power sequencer; one independent radio_seq_lane per lane,
// all on a shared clock.
// Ports (all vectors are BIT_WIDTH wide, bit i = lane i):
//   ck, arst_n         : clock, async active-low reset
//   radioEnableSynced  : lane enable (synchronized)
//   radioRxEnSynced    : lane mode, 1 = RX, 0 = TX (synchronized)
//   errClr             : clears seqErr
//   ldoEn, txPathEn, rxPathEn : supply / path enables
//   laneReady          : lane in TX or RX
//   readyPulse         : one cycle on entry to TX/RX from warm-up
//   seqErr             : sticky "RX requested without enable" flag
// -----------------------------------------------------------------------------
module radio_seq
    import radio_seq_pkg::*;
#(
    parameter int BIT_WIDTH = 2,
    parameter int WARM_CYC  = 16,
    parameter int COOL_CYC  = 8
) (
    input  logic                 ck,
    input  logic                 arst_n,
    input  logic [BIT_WIDTH-1:0] radioEnableSynced,
    input  logic [BIT_WIDTH-1:0] radioRxEnSynced,
    input  logic [BIT_WIDTH-1:0] errClr,
    output logic [BIT_WIDTH-1:0] ldoEn,
    output logic [BIT_WIDTH-1:0] txPathEn,
    output logic [BIT_WIDTH-1:0] rxPathEn,
    output logic [BIT_WIDTH-1:0] laneReady,
    output logic [BIT_WIDTH-1:0] readyPulse,
    output logic [BIT_WIDTH-1:0] seqErr
);

    // A zero-length warm-up or cool-down would underflow the counter load.
    if (WARM_CYC < 1) begin : g_bad_warm
        $error("radio_seq: WARM_CYC must be >= 1");
    end
    if (COOL_CYC < 1) begin : g_bad_cool
        $error("radio_seq: COOL_CYC must be >= 1");
    end

    for (genvar g = 0; g < BIT_WIDTH; g++) begin : g_lane
        radio_seq_lane #(
            .WARM_CYC (WARM_CYC),
            .COOL_CYC (COOL_CYC)
        ) u_lane (
            .ck            (ck),
            .arst_n        (arst_n),
            .i_en          (radioEnableSynced[g]),
            .i_rx          (radioRxEnSynced[g]),
            .i_err_clr     (errClr[g]),
            .o_ldo_en      (ldoEn[g]),
            .o_tx_path_en  (txPathEn[g]),
            .o_rx_path_en  (rxPathEn[g]),
            .o_lane_ready  (laneReady[g]),
            .o_ready_pulse (readyPulse[g]),
            .o_seq_err     (seqErr[g])
        );
    end

endmodule

// File: tb/tb_radio_seq.sv
// -----------------------------------------------------------------------------
// tb_radio_seq
// Self-checking bench for radio_seq: directed scenarios followed by random
// enable/mode/clear traffic, all compared every cycle against a behavioural
// model that tracks "remaining warm cycles", "remaining cool cycles" and the
// active path per lane.
// -----------------------------------------------------------------------------
module tb_radio_seq;

    localparam int NL = 2;
    localparam int WC = 16;
    localparam int CC = 8;

    logic          ck = 1'b0;
    logic          arst_n;
    logic [NL-1:0] en;
    logic [NL-1:0] rx;
    logic [NL-1:0] clr;
    logic [NL-1:0] ldoEn;
    logic [NL-1:0] txPathEn;
    logic [NL-1:0] rxPathEn;
    logic [NL-1:0] laneReady;
    logic [NL-1:0] readyPulse;
    logic [NL-1:0] seqErr;

    radio_seq #(
        .BIT_WIDTH (NL),
        .WARM_CYC  (WC),
        .COOL_CYC  (CC)
    ) dut (
        .ck                (ck),
        .arst_n            (arst_n),
        .radioEnableSynced (en),
        .radioRxEnSynced   (rx),
        .errClr            (clr),
        .ldoEn             (ldoEn),
        .txPathEn          (txPathEn),
        .rxPathEn          (rxPathEn),
        .laneReady         (laneReady),
        .readyPulse        (readyPulse),
        .seqErr            (seqErr)
    );

    always #5 ck = ~ck;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // powered: LDO is up. warm_left / cool_left: cycles of that phase still
    // to come (including the current one). path: 0 none, 1 TX, 2 RX.
    // dead: currently in the one-cycle break-before-make gap.
    bit m_powered [NL];
    int m_warm_left [NL];
    int m_cool_left [NL];
    int m_path [NL];
    bit m_dead [NL];
    bit m_pulse [NL];
    bit m_err [NL];

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_powered[i]   = 1'b0;
            m_warm_left[i] = 0;
            m_cool_left[i] = 0;
            m_path[i]      = 0;
            m_dead[i]      = 1'b0;
            m_pulse[i]     = 1'b0;
            m_err[i]       = 1'b0;
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < NL; i++) begin
            bit is_off;
            is_off     = !m_powered[i];
            m_err[i]   = (is_off && !en[i] && rx[i]) || (m_err[i] && !clr[i]);
            m_pulse[i] = 1'b0;
            if (is_off) begin
                if (en[i]) begin
                    m_powered[i]   = 1'b1;
                    m_warm_left[i] = WC;
                end
            end else if (m_warm_left[i] > 0) begin
                if (!en[i]) begin
                    m_warm_left[i] = 0;
                    m_cool_left[i] = CC;
                end else if (m_warm_left[i] == 1) begin
                    m_warm_left[i] = 0;
                    m_path[i]      = rx[i] ? 2 : 1;
                    m_pulse[i]     = 1'b1;
                end else begin
                    m_warm_left[i]--;
                end
            end else if (m_cool_left[i] > 0) begin
                m_cool_left[i]--;
                if (m_cool_left[i] == 0) m_powered[i] = 1'b0;
            end else if (m_dead[i]) begin
                m_dead[i] = 1'b0;
                if (!en[i]) m_cool_left[i] = CC;
                else        m_path[i] = rx[i] ? 2 : 1;
            end else begin
                if (!en[i]) begin
                    m_path[i]      = 0;
                    m_cool_left[i] = CC;
                end else if (rx[i] != (m_path[i] == 2)) begin
                    m_path[i] = 0;
                    m_dead[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic [NL-1:0] e_ldo, e_tx, e_rx, e_rdy, e_pls, e_err;
        for (int i = 0; i < NL; i++) begin
            e_ldo[i] = m_powered[i];
            e_tx[i]  = (m_path[i] == 1);
            e_rx[i]  = (m_path[i] == 2);
            e_rdy[i] = (m_path[i] != 0);
            e_pls[i] = m_pulse[i];
            e_err[i] = m_err[i];
        end
        check({ph, "/ldoEn"},      32'(ldoEn),      32'(e_ldo));
        check({ph, "/txPathEn"},   32'(txPathEn),   32'(e_tx));
        check({ph, "/rxPathEn"},   32'(rxPathEn),   32'(e_rx));
        check({ph, "/laneReady"},  32'(laneReady),  32'(e_rdy));
        check({ph, "/readyPulse"}, 32'(readyPulse), 32'(e_pls));
        check({ph, "/seqErr"},     32'(seqErr),     32'(e_err));
    endtask

    // One clock: inputs were driven at the previous falling edge, the model
    // advances on the rising edge, outputs are compared at the falling edge.
    task automatic step(input string ph);
        @(posedge ck);
        if (arst_n) model_tick();
        @(negedge ck);
        check_all(ph);
    endtask

    // Path exclusivity is checked on every cycle, including during reset.
    always @(negedge ck) begin
        check("excl", 32'(txPathEn & rxPathEn), 32'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_ldo;
        int first_tx;
        int off_at;
        bit seen;

        en = '0; rx = '0; clr = '0; arst_n = 1'b0;
        model_reset();
        #1 check_all("reset");
        repeat (2) @(negedge ck);
        check_all("reset_hold");
        arst_n = 1'b1;

        // 1: power-up latency on lane 0 in TX mode, lane 1 stays idle.
        en[0] = 1'b1;
        first_ldo = 0; first_tx = 0;
        for (int k = 1; k <= 40; k++) begin
            step("t1");
            if (ldoEn[0] && first_ldo == 0) first_ldo = k;
            if (txPathEn[0]) begin
                first_tx = k;
                check("t1_pulse_on", 32'(readyPulse[0]), 32'd1);
                break;
            end
        end
        check("t1_ldo_latency", first_ldo, 1);
        check("t1_tx_latency", first_tx, WC + 1);
        step("t1b");
        check("t1_pulse_off", 32'(readyPulse[0]), 32'd0);

        // 2: TX -> RX through one SWAP cycle.
        rx[0] = 1'b1;
        step("t2_swap");
        check("t2_swap_paths", 32'({txPathEn[0], rxPathEn[0]}), 32'd0);
        check("t2_swap_ready", 32'(laneReady[0]), 32'd0);
        check("t2_swap_ldo", 32'(ldoEn[0]), 32'd1);
        step("t2_rx");
        check("t2_rx_on", 32'(rxPathEn[0]), 32'd1);
        check("t2_no_pulse", 32'(readyPulse[0]), 32'd0);
        repeat (3) step("t2_hold");

        // 3: shutdown from RX, with enable re-raised during cool-down.
        en[0] = 1'b0;
        step("t3_cool");
        check("t3_rx_off", 32'(rxPathEn[0]), 32'd0);
        en[0] = 1'b1;
        off_at = 0;
        for (int k = 2; k <= 20; k++) begin
            step("t3");
            if (!ldoEn[0]) begin
                off_at = k;
                break;
            end
        end
        check("t3_ldo_off_latency", off_at, CC + 1);
        step("t3_rewarm");
        check("t3_rewarm_ldo", 32'(ldoEn[0]), 32'd1);

        // 4: drop enable in warm-up at count 5; no path, no pulse.
        en[0] = 1'b0;
        for (int k = 0; k < 30 && ldoEn[0]; k++) step("t4_drain");
        en[0] = 1'b1;
        repeat (WC - 5) step("t4_warm");
        en[0] = 1'b0;
        seen = 1'b0;
        repeat (CC + 4) begin
            step("t4_cool");
            seen |= txPathEn[0] | rxPathEn[0] | readyPulse[0];
        end
        check("t4_no_path", 32'(seen), 32'd0);
        check("t4_off", 32'(ldoEn[0]), 32'd0);

        // 5: sticky sequencing error, clear, and set-beats-clear.
        rx[0] = 1'b0; clr[0] = 1'b1;
        step("t5_pre");
        clr[0] = 1'b0;
        check("t5_clean", 32'(seqErr[0]), 32'd0);
        rx[0] = 1'b1;
        step("t5_set");
        check("t5_set", 32'(seqErr[0]), 32'd1);
        rx[0] = 1'b0;
        repeat (3) step("t5_hold");
        check("t5_held", 32'(seqErr[0]), 32'd1);
        clr[0] = 1'b1;
        step("t5_clr");
        check("t5_cleared", 32'(seqErr[0]), 32'd0);
        rx[0] = 1'b1;
        step("t5_both");
        check("t5_set_wins", 32'(seqErr[0]), 32'd1);
        clr[0] = 1'b0; rx[0] = 1'b0;
        step("t5_done");

        // 6: async reset mid-TX on both lanes.
        en = '1; rx = '0;
        repeat (WC + 3) step("t6_up");
        check("t6_both_tx", 32'(txPathEn), 32'(2'b11));
        @(posedge ck);
        model_tick();
        #2 arst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_ldo", 32'(ldoEn), 32'd0);
        check("t6_rst_paths", 32'(txPathEn | rxPathEn | laneReady), 32'd0);
        check("t6_rst_misc", 32'(readyPulse | seqErr), 32'd0);
        repeat (2) step("t6_in_reset");
        arst_n = 1'b1;
        step("t6_resume");
        check("t6_resume_ldo", 32'(ldoEn), 32'(2'b11));
        check("t6_resume_notx", 32'(txPathEn), 32'd0);

        // Random traffic: slow toggles so lanes actually reach TX/RX.
        repeat (4000) begin
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 39) == 0) en[i]  = ~en[i];
                if ($urandom_range(0, 19) == 0) rx[i]  = ~rx[i];
                clr[i] = ($urandom_range(0, 7) == 0);
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
